// File: rtl/enc_chk_pkg.sv
// Shared types and the magnitude-code function for the encoder compare controller.
package enc_chk_pkg;

  localparam int CODE_W = 4;
  localparam int IN_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Position of the highest set bit; 0 and 1 both fold into the low codes (0 -> 0, 1 -> 1).
  function automatic logic [CODE_W-1:0] code_of(input logic [IN_W-1:0] v);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int k = 0; k < IN_W; k++) begin
      if (v[k]) c = CODE_W'(k);
    end
    if (v == IN_W'(1)) c = CODE_W'(1);
    return c;
  endfunction

endpackage

// File: rtl/mag_encoder.sv
// Combinational magnitude encoder: IN_W-bit word to its CODE_W-bit log2 code.
module mag_encoder
  import enc_chk_pkg::*;
(
  input  logic [IN_W-1:0]   din,
  output logic [CODE_W-1:0] code
);

  assign code = code_of(din);

endmodule

// File: rtl/enc_check_ctrl.sv
// Golden-code capture, N-sample live-code compare and i[0] double-fall trigger watch.
//   state     | meaning
//   ST_IDLE   | waiting; ref_load captures golden code, start launches a run
//   ST_SAMPLE | comparing code(i) to ref_code each edge, down-counting samples
//   ST_DONE   | one-cycle result presentation (done=1)
module enc_check_ctrl
  import enc_chk_pkg::*;
#(
  parameter int N_SAMPLES = 4,
  parameter int CNT_W     = 4,
  parameter int ALARM_TH  = 2
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   i,
  input  logic              ref_load,
  input  logic              start,
  output logic              ref_valid,
  output logic [CODE_W-1:0] ref_code,
  output logic [CODE_W-1:0] live_code,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              trig_hit,
  output logic              alarm
);

  localparam int                IDX_W    = 4;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_TH   = CNT_W'(ALARM_TH);

  state_e              state_q, state_d;
  logic                ref_valid_q, ref_valid_d;
  logic [CODE_W-1:0]   ref_code_q, ref_code_d;
  logic [CODE_W-1:0]   live_code_q, live_code_d;
  logic                match_q, match_d;
  logic [CNT_W-1:0]    mismatch_cnt_q, mismatch_cnt_d;
  logic                trig_hit_q, trig_hit_d;
  logic                alarm_q, alarm_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                i0_q, i0_d;
  logic [1:0]          edge_cnt_q, edge_cnt_d;

  logic [CODE_W-1:0]   code_now;
  logic                fall;

  mag_encoder u_enc (
    .din  (i),
    .code (code_now)
  );

  assign fall = (state_q == ST_SAMPLE) && i0_q && !i[0];

  always_comb begin
    state_d        = state_q;
    ref_valid_d    = ref_valid_q;
    ref_code_d     = ref_code_q;
    live_code_d    = live_code_q;
    match_d        = match_q;
    mismatch_cnt_d = mismatch_cnt_q;
    trig_hit_d     = trig_hit_q;
    alarm_d        = alarm_q;
    idx_d          = idx_q;
    i0_d           = i[0];
    edge_cnt_d     = edge_cnt_q;

    // Edge bookkeeping first so the DONE-entry alarm sees a trigger on the last sample.
    if (fall) begin
      edge_cnt_d = edge_cnt_q + 2'd1;
      if (edge_cnt_q == 2'd1) trig_hit_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ref_load) begin
          ref_code_d  = code_now;
          ref_valid_d = 1'b1;
        end else if (start && ref_valid_q) begin
          state_d        = ST_SAMPLE;
          mismatch_cnt_d = '0;
          trig_hit_d     = 1'b0;
          match_d        = 1'b0;
          alarm_d        = 1'b0;
          edge_cnt_d     = 2'd0;
          idx_d          = IDX_LAST;
        end
      end

      ST_SAMPLE: begin
        live_code_d = code_now;
        if ((code_now != ref_code_q) && (mismatch_cnt_q != CNT_MAX)) begin
          mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
        end
        if (idx_q == '0) begin
          state_d = ST_DONE;
          match_d = (mismatch_cnt_d == '0);
          alarm_d = (mismatch_cnt_d >= CNT_TH) || trig_hit_d;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ref_valid_q    <= 1'b0;
      ref_code_q     <= '0;
      live_code_q    <= '0;
      match_q        <= 1'b0;
      mismatch_cnt_q <= '0;
      trig_hit_q     <= 1'b0;
      alarm_q        <= 1'b0;
      idx_q          <= '0;
      i0_q           <= 1'b0;
      edge_cnt_q     <= 2'd0;
    end else begin
      state_q        <= state_d;
      ref_valid_q    <= ref_valid_d;
      ref_code_q     <= ref_code_d;
      live_code_q    <= live_code_d;
      match_q        <= match_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      trig_hit_q     <= trig_hit_d;
      alarm_q        <= alarm_d;
      idx_q          <= idx_d;
      i0_q           <= i0_d;
      edge_cnt_q     <= edge_cnt_d;
    end
  end

  assign ref_valid    = ref_valid_q;
  assign ref_code     = ref_code_q;
  assign live_code    = live_code_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign match        = match_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign trig_hit     = trig_hit_q;
  assign alarm        = alarm_q;

endmodule

// File: tb/tb_enc_check_ctrl.sv
// Scoreboard bench for enc_check_ctrl: runs push expected results, a done-monitor pops and compares.
module tb_enc_check_ctrl;
  import enc_chk_pkg::*;

  logic        c = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  i = '0;
  logic        ref_load = 1'b0;
  logic        start = 1'b0;
  logic        ref_valid, busy, done, match, trig_hit, alarm;
  logic [3:0]  ref_code, live_code, mismatch_cnt;

  typedef struct {
    logic       match;
    logic [3:0] cnt;
    logic       alarm;
    logic       trig;
    logic [3:0] live;
    logic [3:0] refc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_done = 0;

  enc_check_ctrl #(.N_SAMPLES(4), .CNT_W(4), .ALARM_TH(2)) dut (
    .c            (c),
    .rst_n        (rst_n),
    .i            (i),
    .ref_load     (ref_load),
    .start        (start),
    .ref_valid    (ref_valid),
    .ref_code     (ref_code),
    .live_code    (live_code),
    .busy         (busy),
    .done         (done),
    .match        (match),
    .mismatch_cnt (mismatch_cnt),
    .trig_hit     (trig_hit),
    .alarm        (alarm)
  );

  always #5 c = ~c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ref_valid"}, ref_valid, 0);
    chk({tag, "_ref_code"}, ref_code, 0);
    chk({tag, "_live_code"}, live_code, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_mismatch_cnt"}, mismatch_cnt, 0);
    chk({tag, "_trig_hit"}, trig_hit, 0);
    chk({tag, "_alarm"}, alarm, 0);
  endtask

  // Monitor: results are checked against the queue whenever done is presented.
  always @(negedge c) begin : mon
    exp_t e;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no result pending at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("res_match", match, e.match);
        chk("res_mismatch_cnt", mismatch_cnt, e.cnt);
        chk("res_alarm", alarm, e.alarm);
        chk("res_trig_hit", trig_hit, e.trig);
        chk("res_live_code", live_code, e.live);
        chk("res_ref_code", ref_code, e.refc);
        chk("res_busy", busy, 1);
      end
    end
  end

  // One full check run; the sample values are driven on edges T+1..T+4 after start at T.
  task automatic run(input logic [9:0] pre, input logic [9:0] a0, input logic [9:0] a1,
                     input logic [9:0] a2, input logic [9:0] a3, input bit mid_start,
                     input exp_t e);
    i = pre;
    start = 1'b1;
    sb.push_back(e);
    step();
    start = 1'b0;
    chk("busy_s0", busy, 1);
    chk("done_s0", done, 0);
    i = a0;
    step();
    chk("busy_s1", busy, 1);
    i = a1;
    if (mid_start) start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_s2", busy, 1);
    i = a2;
    step();
    chk("busy_s3", busy, 1);
    i = a3;
    step();
    chk("done_at_start_plus5", done, 1);
    chk("busy_in_done", busy, 1);
    step();
    chk("done_fell", done, 0);
    chk("busy_fell", busy, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  logic [9:0] enc_in  [8] = '{10'd0, 10'd1, 10'd2, 10'd4, 10'd511, 10'd512, 10'd1023, 10'd7};
  logic [3:0] enc_exp [8] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd8, 4'd9, 4'd9, 4'd2};

  initial begin
    // 1. Reset and first golden capture
    step();
    chk_all_zero("rst");
    rst_n = 1'b1;
    i = 10'd100;
    ref_load = 1'b1;
    step();
    ref_load = 1'b0;
    chk("t1_ref_valid", ref_valid, 1);
    chk("t1_ref_code", ref_code, 6);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_match", match, 0);
    chk("t1_cnt", mismatch_cnt, 0);
    chk("t1_trig", trig_hit, 0);
    chk("t1_alarm", alarm, 0);
    chk("t1_live", live_code, 0);

    // 2..4. Check runs
    run(10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 1'b0, '{1'b1, 4'd0, 1'b0, 1'b0, 4'd6, 4'd6});
    run(10'd100, 10'd100, 10'd100, 10'd600, 10'd1,   1'b0, '{1'b0, 4'd2, 1'b1, 1'b0, 4'd1, 4'd6});
    chk("t3_held_match", match, 0);
    chk("t3_held_alarm", alarm, 1);
    run(10'd64,  10'd65,  10'd64,  10'd65,  10'd64,  1'b0, '{1'b1, 4'd0, 1'b1, 1'b1, 4'd6, 4'd6});
    run(10'd64,  10'd64,  10'd64,  10'd64,  10'd64,  1'b0, '{1'b1, 4'd0, 1'b0, 1'b0, 4'd6, 4'd6});

    // Encoder boundaries through golden capture
    for (int k = 0; k < 8; k++) begin
      i = enc_in[k];
      ref_load = 1'b1;
      step();
      ref_load = 1'b0;
      chk("enc_ref_code", ref_code, enc_exp[k]);
    end

    // 5. start without golden code, ref_load priority, start during SAMPLE
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    step();
    chk("t5_noref_busy0", busy, 0);
    step();
    start = 1'b0;
    chk("t5_noref_busy1", busy, 0);
    chk("t5_noref_valid", ref_valid, 0);
    i = 10'd3;
    ref_load = 1'b1;
    start = 1'b1;
    step();
    ref_load = 1'b0;
    start = 1'b0;
    chk("t5_ref_valid", ref_valid, 1);
    chk("t5_ref_code", ref_code, 1);
    chk("t5_no_run", busy, 0);
    step();
    chk("t5_no_run_late", busy, 0);
    run(10'd3, 10'd1, 10'd2, 10'd3, 10'd1, 1'b1, '{1'b1, 4'd0, 1'b0, 1'b0, 4'd1, 4'd1});
    repeat (3) step();
    chk("t5_no_second_run", busy, 0);

    // 6. Reset in the middle of a run
    i = 10'd600;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("t6_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_start_ignored", busy, 0);
    step();
    chk("t6_still_idle", busy, 0);
    i = 10'd1000;
    ref_load = 1'b1;
    step();
    ref_load = 1'b0;
    chk("t6_reload_valid", ref_valid, 1);
    chk("t6_reload_code", ref_code, 9);

    repeat (3) step();
    chk("done_pulse_count", n_done, 5);
    chk("sb_empty_end", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_check_ctrl.md
Name: enc_check_ctrl

Overview:
Sequencing controller for the 10-bit magnitude-encoder compare datapath.
- Captures a golden 4-bit code, then samples the live code for N_SAMPLES cycles and counts mismatches against the golden code.
- Also watches i[0] for the two-falling-edge trigger pattern.
- Reports match/alarm to the security monitor on a one-cycle done pulse.

Parameters:
N_SAMPLES, 4, number of live-code samples per check run (legal range 1..15)
CNT_W, 4, width of mismatch counter (saturating)
ALARM_TH, 2, mismatch count at or above which alarm is raised

Ports:
c  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
i  input  10  datapath input word
ref_load  input  1  capture golden code from i (honoured in IDLE only)
start  input  1  begin check run (honoured in IDLE with ref_valid=1)
ref_valid  output  1  golden code captured
ref_code  output  4  golden code register
live_code  output  4  code of i registered on the last sample
busy  output  1  high while in SAMPLE or DONE
done  output  1  one-cycle pulse in DONE
match  output  1  run result: mismatch_cnt==0; held until next start
mismatch_cnt  output  CNT_W  mismatches counted in current/last run
trig_hit  output  1  sticky: second falling edge of i[0] seen during run
alarm  output  1  (mismatch_cnt>=ALARM_TH) | trig_hit; valid from done, held

Behaviour:
- Code function: i==0 -> 0; 1..3 -> 1; otherwise floor(log2(i)), so 4..7 -> 2, ..., 512..1023 -> 9. Codes 10..15 are never produced.
- Reset (async, rst_n=0):
  - All outputs 0, state IDLE, ref_valid 0.
  - Internal i0_d 0 and edge counter 0.
  - Reset mid-run discards the run and the golden code.
- States: IDLE, SAMPLE, DONE.
- IDLE:
  - ref_load=1: ref_code<=code(i) and ref_valid<=1 at that edge. ref_load has priority over a simultaneous start; that start is dropped.
  - start=1 with ref_valid=1 (and ref_load=0): go to SAMPLE.
    - Clear mismatch_cnt, trig_hit, match, alarm, sample index and edge counter.
  - start with ref_valid=0: ignored, no state change.
- SAMPLE, every edge:
  - live_code<=code(i).
  - If code(i)!=ref_code: mismatch_cnt++, saturating at 2^CNT_W-1.
  - Index++. On the edge where index==N_SAMPLES-1, go to DONE.
  - The compare uses combinational code(i) at that edge, not the registered live_code.
- Edge monitor:
  - i0_d<=i[0] every cycle in every state.
  - A falling edge is i0_d=1 & i[0]=0 detected at an edge while in SAMPLE. It increments a 2-bit wrapping counter.
  - When the counter goes 1->2, trig_hit<=1 (sticky for the run). A third edge (count 3) does not clear it.
- DONE (one cycle):
  - done=1.
  - match=(mismatch_cnt==0) and alarm per formula, registered on the entry edge so they are visible with done.
  - Next edge goes to IDLE.
- Latency: a start sampled at edge T gives sample edges T+1..T+N and done high during cycle T+N+1. busy is high from after T until done falls.
- ref_load or start while busy: ignored. ref_code is stable for the whole run.
- ref_code, ref_valid, match, alarm, mismatch_cnt, trig_hit and live_code hold their values in IDLE.

Decomposition:
- Package enc_chk_pkg:
  - State enum (IDLE/SAMPLE/DONE).
  - CODE_W=4 and IN_W=10.
  - Function code_of(i) implementing the code function.
- One combinational sub-module: mag_encoder (IN_W -> CODE_W), using code_of. The controller instantiates it once.
- Edge monitor and FSM live in enc_check_ctrl.

Test Plan:
1. Reset, then ref_load with i=100 -> next cycle ref_valid=1, ref_code=6; all other outputs 0.
2. start, then i=100 for 4 cycles -> busy for 5 cycles; done at start+5; match=1, mismatch_cnt=0, alarm=0, trig_hit=0.
3. start, then i=100,100,600,1 -> codes 6,6,9,1; mismatch_cnt=2, match=0, alarm=1, live_code=1.
4. start, then i=65,64,65,64 (all code 6) -> mismatch_cnt=0, match=1; two i[0] falls give trig_hit=1 and alarm=1. A repeat run with i=64 constant gives trig_hit=0.
5. After reset, start with ref_valid=0 -> busy stays 0. Then ref_load+start in the same cycle with i=3 -> ref_code=1, no run started. start during SAMPLE -> ignored, done only once.
6. rst_n=0 during cycle 2 of SAMPLE -> all outputs 0 immediately, ref_valid=0; after release, start is ignored until ref_load.
